// File: rtl/rv32i_mc_core.sv
// Two-cycle (FETCH/EXECUTE) RV32I core on one shared 32-bit memory bus.
// Only LW/SW are real memory operations; other loads/stores retire as NOPs.
package rv32i_mc_pkg;
    typedef enum logic [3:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_OTHER
    } opcode_e;

    typedef enum logic [5:0] {
        M_NOP, M_LUI, M_AUIPC, M_JAL, M_JALR,
        M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
        M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
        M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
        M_LW, M_SW
    } mnem_e;
endpackage

module rv32i_mc_decoder
    import rv32i_mc_pkg::*;
(
    input  logic [31:0] ir,
    output opcode_e     opcode,
    output mnem_e       mnemonic,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] imm
);
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_f3     = ir[14:12];
    assign w_f7     = ir[31:25];
    assign rs1_addr = ir[19:15];
    assign rs2_addr = ir[24:20];
    assign rd_addr  = ir[11:7];

    assign w_imm_i = {{20{ir[31]}}, ir[31:20]};
    assign w_imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign w_imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign w_imm_u = {ir[31:12], 12'b0};
    assign w_imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Anything not decoded exactly falls through as M_NOP.
    always_comb begin
        opcode   = OP_OTHER;
        mnemonic = M_NOP;
        imm      = '0;
        case (ir[6:0])
            7'b0110111: begin opcode = OP_LUI;   mnemonic = M_LUI;   imm = w_imm_u; end
            7'b0010111: begin opcode = OP_AUIPC; mnemonic = M_AUIPC; imm = w_imm_u; end
            7'b1101111: begin opcode = OP_JAL;   mnemonic = M_JAL;   imm = w_imm_j; end
            7'b1100111: begin
                opcode = OP_JALR;
                imm    = w_imm_i;
                if (w_f3 == 3'b000) mnemonic = M_JALR;
            end
            7'b1100011: begin
                opcode = OP_BRANCH;
                imm    = w_imm_b;
                case (w_f3)
                    3'b000:  mnemonic = M_BEQ;
                    3'b001:  mnemonic = M_BNE;
                    3'b100:  mnemonic = M_BLT;
                    3'b101:  mnemonic = M_BGE;
                    3'b110:  mnemonic = M_BLTU;
                    3'b111:  mnemonic = M_BGEU;
                    default: mnemonic = M_NOP;
                endcase
            end
            7'b0000011: begin
                opcode = OP_LOAD;
                imm    = w_imm_i;
                if (w_f3 == 3'b010) mnemonic = M_LW;
            end
            7'b0100011: begin
                opcode = OP_STORE;
                imm    = w_imm_s;
                if (w_f3 == 3'b010) mnemonic = M_SW;
            end
            7'b0010011: begin
                opcode = OP_IMM;
                imm    = w_imm_i;
                case (w_f3)
                    3'b000: mnemonic = M_ADDI;
                    3'b010: mnemonic = M_SLTI;
                    3'b011: mnemonic = M_SLTIU;
                    3'b100: mnemonic = M_XORI;
                    3'b110: mnemonic = M_ORI;
                    3'b111: mnemonic = M_ANDI;
                    3'b001: mnemonic = (w_f7 == 7'h00) ? M_SLLI : M_NOP;
                    default: begin
                        if (w_f7 == 7'h00)      mnemonic = M_SRLI;
                        else if (w_f7 == 7'h20) mnemonic = M_SRAI;
                    end
                endcase
            end
            7'b0110011: begin
                opcode = OP_REG;
                case ({w_f7, w_f3})
                    {7'h00, 3'b000}: mnemonic = M_ADD;
                    {7'h20, 3'b000}: mnemonic = M_SUB;
                    {7'h00, 3'b001}: mnemonic = M_SLL;
                    {7'h00, 3'b010}: mnemonic = M_SLT;
                    {7'h00, 3'b011}: mnemonic = M_SLTU;
                    {7'h00, 3'b100}: mnemonic = M_XOR;
                    {7'h00, 3'b101}: mnemonic = M_SRL;
                    {7'h20, 3'b101}: mnemonic = M_SRA;
                    {7'h00, 3'b110}: mnemonic = M_OR;
                    {7'h00, 3'b111}: mnemonic = M_AND;
                    default:         mnemonic = M_NOP;
                endcase
            end
            default: ;
        endcase
    end
endmodule

module rv32i_mc_core
    import rv32i_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_rddata,
    output logic [31:0] bus_addr,
    output logic        bus_wren,
    output logic [31:0] bus_wrdata
);
    typedef enum logic {S_FETCH, S_EXEC} state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_regs [NUM_REGS];

    opcode_e     w_opcode;
    mnem_e       w_mnem;
    logic [4:0]  w_rs1_addr, w_rs2_addr, w_rd_addr;
    logic [31:0] w_imm;
    logic [31:0] w_rs1, w_rs2, w_pc4, w_ea;
    logic [31:0] w_result, w_next_pc;
    logic        w_we;
    logic        w_exec;

    rv32i_mc_decoder decoder (
        .ir       (r_ir),
        .opcode   (w_opcode),
        .mnemonic (w_mnem),
        .rs1_addr (w_rs1_addr),
        .rs2_addr (w_rs2_addr),
        .rd_addr  (w_rd_addr),
        .imm      (w_imm)
    );

    assign w_rs1  = (w_rs1_addr == 5'd0) ? 32'd0 : r_regs[w_rs1_addr];
    assign w_rs2  = (w_rs2_addr == 5'd0) ? 32'd0 : r_regs[w_rs2_addr];
    assign w_pc4  = r_pc + 32'd4;
    assign w_ea   = w_rs1 + w_imm;
    assign w_exec = (r_state == S_EXEC);

    assign bus_addr   = (w_exec && (w_opcode == OP_LOAD || w_opcode == OP_STORE)) ? w_ea : r_pc;
    assign bus_wren   = w_exec && (w_mnem == M_SW);
    assign bus_wrdata = bus_wren ? w_rs2 : 32'd0;

    always_comb begin
        w_we      = 1'b0;
        w_result  = 32'd0;
        w_next_pc = w_pc4;
        case (w_mnem)
            M_LUI:   begin w_we = 1'b1; w_result = w_imm; end
            M_AUIPC: begin w_we = 1'b1; w_result = r_pc + w_imm; end
            M_JAL:   begin w_we = 1'b1; w_result = w_pc4; w_next_pc = r_pc + w_imm; end
            M_JALR:  begin w_we = 1'b1; w_result = w_pc4; w_next_pc = w_ea & ~32'd1; end
            M_BEQ:   if (w_rs1 == w_rs2) w_next_pc = r_pc + w_imm;
            M_BNE:   if (w_rs1 != w_rs2) w_next_pc = r_pc + w_imm;
            M_BLT:   if ($signed(w_rs1) <  $signed(w_rs2)) w_next_pc = r_pc + w_imm;
            M_BGE:   if ($signed(w_rs1) >= $signed(w_rs2)) w_next_pc = r_pc + w_imm;
            M_BLTU:  if (w_rs1 <  w_rs2) w_next_pc = r_pc + w_imm;
            M_BGEU:  if (w_rs1 >= w_rs2) w_next_pc = r_pc + w_imm;
            M_ADDI:  begin w_we = 1'b1; w_result = w_ea; end
            M_SLTI:  begin w_we = 1'b1; w_result = {31'd0, $signed(w_rs1) < $signed(w_imm)}; end
            M_SLTIU: begin w_we = 1'b1; w_result = {31'd0, w_rs1 < w_imm}; end
            M_XORI:  begin w_we = 1'b1; w_result = w_rs1 ^ w_imm; end
            M_ORI:   begin w_we = 1'b1; w_result = w_rs1 | w_imm; end
            M_ANDI:  begin w_we = 1'b1; w_result = w_rs1 & w_imm; end
            M_SLLI:  begin w_we = 1'b1; w_result = w_rs1 << w_imm[4:0]; end
            M_SRLI:  begin w_we = 1'b1; w_result = w_rs1 >> w_imm[4:0]; end
            M_SRAI:  begin w_we = 1'b1; w_result = $unsigned($signed(w_rs1) >>> w_imm[4:0]); end
            M_ADD:   begin w_we = 1'b1; w_result = w_rs1 + w_rs2; end
            M_SUB:   begin w_we = 1'b1; w_result = w_rs1 - w_rs2; end
            M_SLL:   begin w_we = 1'b1; w_result = w_rs1 << w_rs2[4:0]; end
            M_SLT:   begin w_we = 1'b1; w_result = {31'd0, $signed(w_rs1) < $signed(w_rs2)}; end
            M_SLTU:  begin w_we = 1'b1; w_result = {31'd0, w_rs1 < w_rs2}; end
            M_XOR:   begin w_we = 1'b1; w_result = w_rs1 ^ w_rs2; end
            M_SRL:   begin w_we = 1'b1; w_result = w_rs1 >> w_rs2[4:0]; end
            M_SRA:   begin w_we = 1'b1; w_result = $unsigned($signed(w_rs1) >>> w_rs2[4:0]); end
            M_OR:    begin w_we = 1'b1; w_result = w_rs1 | w_rs2; end
            M_AND:   begin w_we = 1'b1; w_result = w_rs1 & w_rs2; end
            M_LW:    begin w_we = 1'b1; w_result = bus_rddata; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 32'd0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= bus_rddata;
                    r_state <= S_EXEC;
                end
                default: begin
                    if (w_we && w_rd_addr != 5'd0) r_regs[w_rd_addr] <= w_result;
                    r_pc    <= w_next_pc;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: small ROM/RAM model on the shared bus,
// programs hand-assembled, architectural state checked after each step.
module tb_rv32i_mc_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_rddata;
    logic [31:0] bus_addr;
    logic        bus_wren;
    logic [31:0] bus_wrdata;

    logic [31:0] rom [64];
    logic [31:0] ram [64];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32i_mc_core dut (
        .clk        (clk),
        .rst        (rst),
        .bus_rddata (bus_rddata),
        .bus_addr   (bus_addr),
        .bus_wren   (bus_wren),
        .bus_wrdata (bus_wrdata)
    );

    assign bus_rddata = bus_addr[28] ? ram[bus_addr[7:2]] : rom[bus_addr[7:2]];

    always @(posedge clk)
        if (bus_wren && bus_addr[28]) ram[bus_addr[7:2]] <= bus_wrdata;

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                                          logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
        rom[0]  = 32'h0050_0093;                               // ADDI x1,x0,5
        rom[1]  = enc_i(7'b0010011, 3'b000, 5'd2, 5'd1, 12'hFFD); // ADDI x2,x1,-3
        rom[2]  = enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'h007); // ADDI x0,x0,7
        rom[3]  = enc_u(7'b0110111, 5'd5, 20'h10010);          // LUI x5,0x10010
        rom[4]  = enc_s(12'd0, 5'd2, 5'd5);                    // SW x2,0(x5)
        rom[5]  = enc_i(7'b0000011, 3'b010, 5'd3, 5'd5, 12'd0);   // LW x3,0(x5)
        rom[6]  = enc_i(7'b0010011, 3'b000, 5'd6, 5'd0, 12'hFFF); // ADDI x6,x0,-1
        rom[7]  = enc_i(7'b0010011, 3'b000, 5'd7, 5'd0, 12'd1);   // ADDI x7,x0,1
        rom[8]  = enc_r(7'h00, 5'd7, 5'd6, 3'b010, 5'd8);      // SLT x8,x6,x7
        rom[9]  = enc_r(7'h00, 5'd7, 5'd6, 3'b011, 5'd9);      // SLTU x9,x6,x7
        rom[10] = enc_b(13'd8, 5'd7, 5'd6, 3'b100);            // BLT x6,x7,+8
        rom[11] = enc_i(7'b0010011, 3'b000, 5'd10, 5'd0, 12'd99);
        rom[12] = enc_b(13'd8, 5'd7, 5'd6, 3'b110);            // BLTU x6,x7,+8
        rom[13] = enc_i(7'b0010011, 3'b000, 5'd11, 5'd0, 12'd42);
        rom[14] = enc_i(7'b0010011, 3'b101, 5'd12, 5'd6, 12'h004); // SRLI x12,x6,4
        rom[15] = enc_i(7'b0010011, 3'b101, 5'd6, 5'd6, 12'h404);  // SRAI x6,x6,4
        rom[16] = enc_r(7'h20, 5'd6, 5'd7, 3'b000, 5'd13);     // SUB x13,x7,x6
        rom[17] = enc_u(7'b0010111, 5'd14, 20'h00001);         // AUIPC x14,1
        rom[18] = enc_i(7'b0010011, 3'b100, 5'd15, 5'd7, 12'hFFF); // XORI x15,x7,-1
        rom[19] = enc_r(7'h00, 5'd11, 5'd7, 3'b001, 5'd16);    // SLL x16,x7,x11
        rom[20] = enc_b(13'd8, 5'd6, 5'd7, 3'b101);            // BGE x7,x6,+8
        rom[21] = enc_i(7'b0010011, 3'b000, 5'd10, 5'd0, 12'd1);
        rom[22] = 32'h0000_0073;                               // ECALL as NOP
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
        load_prog_a();

        tick(2);
        chk("rst_addr", bus_addr, 32'h0040_0000);
        chk("rst_wren", {31'd0, bus_wren}, 32'd0);
        chk("rst_wrdata", bus_wrdata, 32'd0);
        rst = 1'b0;

        tick(1);
        chk("ir_latch", dut.r_ir, 32'h0050_0093);
        chk("exec_addr", bus_addr, 32'h0040_0000);
        tick(1);
        chk("addi_x1", dut.r_regs[1], 32'd5);
        tick(2);
        chk("addi_x2", dut.r_regs[2], 32'd2);
        chk("pc_4cyc", dut.r_pc, 32'h0040_0008);
        tick(2);
        chk("x0_zero", dut.r_regs[0], 32'd0);
        tick(2);
        chk("lui_x5", dut.r_regs[5], 32'h1001_0000);
        tick(1);
        chk("sw_addr", bus_addr, 32'h1001_0000);
        chk("sw_wren", {31'd0, bus_wren}, 32'd1);
        chk("sw_wrdata", bus_wrdata, 32'd2);
        tick(1);
        chk("sw_ram", ram[0], 32'd2);
        chk("sw_wren_off", {31'd0, bus_wren}, 32'd0);
        tick(2);
        chk("lw_x3", dut.r_regs[3], 32'd2);
        tick(4);
        chk("x6_m1", dut.r_regs[6], 32'hFFFF_FFFF);
        chk("x7_1", dut.r_regs[7], 32'd1);
        tick(2);
        chk("slt", dut.r_regs[8], 32'd1);
        tick(2);
        chk("sltu", dut.r_regs[9], 32'd0);
        tick(2);
        chk("blt_taken", dut.r_pc, 32'h0040_0030);
        tick(2);
        chk("bltu_not", dut.r_pc, 32'h0040_0034);
        tick(2);
        chk("after_bltu", dut.r_regs[11], 32'd42);
        chk("blt_skip", dut.r_regs[10], 32'd0);
        tick(2);
        chk("srli", dut.r_regs[12], 32'h0FFF_FFFF);
        tick(2);
        chk("srai", dut.r_regs[6], 32'hFFFF_FFFF);
        tick(2);
        chk("sub", dut.r_regs[13], 32'd2);
        tick(2);
        chk("auipc", dut.r_regs[14], 32'h0040_1044);
        tick(2);
        chk("xori", dut.r_regs[15], 32'hFFFF_FFFE);
        tick(2);
        chk("sll", dut.r_regs[16], 32'h0000_0400);
        tick(2);
        chk("bge_taken", dut.r_pc, 32'h0040_0058);
        tick(2);
        chk("ecall_nop", dut.r_pc, 32'h0040_005C);
        chk("ecall_x10", dut.r_regs[10], 32'd0);

        // JAL / JALR program
        rst = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
        rom[4] = enc_j(21'd12, 5'd1);                          // JAL x1,+12
        rom[5] = enc_i(7'b0010011, 3'b000, 5'd13, 5'd0, 12'd7);
        rom[7] = enc_i(7'b1100111, 3'b000, 5'd0, 5'd1, 12'd0); // JALR x0,0(x1)
        tick(2);
        chk("rst2_x13", dut.r_regs[13], 32'd0);
        rst = 1'b0;
        tick(10);
        chk("jal_link", dut.r_regs[1], 32'h0040_0014);
        chk("jal_fetch", bus_addr, 32'h0040_001C);
        tick(2);
        chk("jalr_fetch", bus_addr, 32'h0040_0014);
        tick(2);
        chk("jalr_land", dut.r_regs[13], 32'd7);

        // Reset in the middle of a SW execute
        rst = 1'b1;
        load_prog_a();
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
        tick(2);
        rst = 1'b0;
        tick(9);
        chk("pre_rst_wren", {31'd0, bus_wren}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wren", {31'd0, bus_wren}, 32'd0);
        chk("mid_rst_pc", dut.r_pc, 32'h0040_0000);
        chk("mid_rst_x5", dut.r_regs[5], 32'd0);
        chk("mid_rst_x1", dut.r_regs[1], 32'd0);
        chk("mid_rst_addr", bus_addr, 32'h0040_0000);
        tick(1);
        chk("mid_rst_ram", ram[0], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
